gcd_lcm_engine: RTL and testbench
=================================

// Module: gcd_lcm_engine
// PURPOSE
//  Parametrised iterative GCD/LCM engine; next generation of the team's GCD unit.
//  Adds WIDTH generality, valid/ready handshakes on both sides, and an LCM mode.
//  GCD uses binary (Stein) reduction, so there is no divider in the GCD path.
//  LCM = (a / gcd) * b: sequential restoring divide, then a registered multiply.
//  Sits between a CSR/stream front-end and a result consumer.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=2); result is 2*WIDTH bits
// PORTS
//  clk        in   1        single clock, all logic on posedge
//  reset      in   1        synchronous, active-high; clears all state
//  in_valid   in   1        operand/mode presented
//  in_ready   out  1        engine can accept; 1 only in IDLE
//  mode       in   1        0 = GCD, 1 = LCM; sampled with operands
//  a, b       in   WIDTH    operands, unsigned
//  out_valid  out  1        result/zero_op valid; held until out_ready
//  out_ready  in   1        consumer accepts result
//  result     out  2*WIDTH  GCD zero-extended, or full LCM
//  zero_op    out  1        an operand was 0 (qualified by out_valid)
//  busy       out  1        1 in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, zero_op=0.
//  Reset mid-operation discards the job. No output is produced for it.
//  Accept: in_valid&&in_ready at a clk edge latches a, b and mode into x, y and m.
//   The same edge clears shift count k and enters STRIP.
//  States and transitions, one step per cycle:
//   IDLE   -> STRIP on accept.
//   STRIP  if x==0 or y==0: result per the zero rules below, then DONE.
//          elif x and y both even: x>>=1, y>>=1, k++.
//          else -> REDUCE.
//   REDUCE if x==0: g=y<<k, then GCD mode -> DONE, LCM mode -> DIV.
//          elif x even: x>>=1.  elif y even: y>>=1.
//          elif x>=y: x=x-y.  else: y=y-x.
//   DIV    restoring divide of the latched a by g, one quotient bit per cycle.
//          Takes exactly WIDTH cycles, then -> MUL.
//   MUL    result = q*b (WIDTH x WIDTH -> 2*WIDTH, registered). 1 cycle, then -> DONE.
//   DONE   out_valid=1. Stay in DONE while !out_ready.
//          out_valid&&out_ready -> IDLE and clear out_valid at that edge.
//  Zero rules: gcd(0,b)=b, gcd(a,0)=a, gcd(0,0)=0. LCM with any zero operand = 0.
//   zero_op=1 in all these cases. Total latency is 2 cycles (accept -> out_valid).
//  result, zero_op and mode are stable while out_valid=1. No new accept in DONE.
//  Latency bound (nonzero operands): GCD <= 3*WIDTH+2 cycles. LCM adds WIDTH+1 cycles.
//  No overflow is possible: lcm(a,b) <= a*b < 2^(2*WIDTH).
//  Subtraction is WIDTH-bit. x>=y is guaranteed before subtracting, so no wrap.
//  k <= WIDTH-1. Its width is $clog2(WIDTH).
// TESTING
//  1. WIDTH=8, GCD, a=48, b=18 -> result=6, zero_op=0, out_valid within 26 cycles.
//  2. LCM, a=4, b=6 -> result=12. Also a=255, b=255 -> result=255.
//  3. GCD a=0, b=0 -> result=0, zero_op=1, out_valid 2 cycles after accept.
//     Also LCM a=0, b=9 -> result=0, zero_op=1.
//  4. Backpressure: out_ready=0 for 10 cycles after gcd(21,14) -> result=7 holds.
//     in_ready stays 0 and in_valid is ignored. Release -> IDLE next cycle.
//  5. Reset asserted during REDUCE -> next cycle in_ready=1, out_valid=0, busy=0.
//     A new job gcd(9,6) then returns 3.
//  6. WIDTH=16, LCM a=65535, b=65534 -> result=4294770690.
//     Random sweep vs reference model, >=1000 pairs in each mode.

Source files
------------

// File: rtl/gcd_lcm_engine.sv
// gcd_lcm_engine: iterative GCD/LCM unit with valid/ready handshakes on both sides.
// GCD is computed with binary (Stein) reduction, so the GCD path needs no divider.
// LCM is formed as (a / gcd) * b, using a one-bit-per-cycle restoring divide
// followed by one registered WIDTH x WIDTH multiply.
module gcd_lcm_engine #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero_op,
    output logic                 busy
);

    // k never exceeds WIDTH-1 and the divide counter counts WIDTH-1 down to 0,
    // so both fit in $clog2(WIDTH) bits.
    localparam int KW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        STRIP,
        REDUCE,
        DIV,
        MUL,
        DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     x_reg, x_next;
    logic [WIDTH-1:0]     y_reg, y_next;
    logic [KW-1:0]        k_reg, k_next;
    logic                 m_reg, m_next;
    logic [WIDTH-1:0]     a_reg, a_next;
    logic [WIDTH-1:0]     b_reg, b_next;
    logic [WIDTH-1:0]     g_reg, g_next;
    logic [WIDTH-1:0]     q_reg, q_next;
    logic [WIDTH-1:0]     rem_reg, rem_next;
    logic [KW-1:0]        cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic                 zero_op_reg, zero_op_next;

    logic [WIDTH:0]       div_shifted;
    logic [WIDTH:0]       div_diff;
    logic [WIDTH-1:0]     gcd_val;
    logic [2*WIDTH-1:0]   product;

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg       <= '0;
            y_reg       <= '0;
            k_reg       <= '0;
            m_reg       <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
            g_reg       <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            zero_op_reg <= 1'b0;
        end else begin
            x_reg       <= x_next;
            y_reg       <= y_next;
            k_reg       <= k_next;
            m_reg       <= m_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            g_reg       <= g_next;
            q_reg       <= q_next;
            rem_reg     <= rem_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
            zero_op_reg <= zero_op_next;
        end
    end

    // Next-state and datapath update: one reduction / divide / multiply step per cycle.
    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        k_next       = k_reg;
        m_next       = m_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        g_next       = g_reg;
        q_next       = q_reg;
        rem_next     = rem_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;
        zero_op_next = zero_op_reg;

        // Restoring-divide step: bring the next dividend bit into the partial remainder.
        div_shifted = {rem_reg, q_reg[WIDTH-1]};
        div_diff    = div_shifted - {1'b0, g_reg};
        gcd_val     = y_reg << k_reg;
        product     = {{WIDTH{1'b0}}, q_reg} * {{WIDTH{1'b0}}, b_reg};

        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    x_next       = a;
                    y_next       = b;
                    a_next       = a;
                    b_next       = b;
                    m_next       = mode;
                    k_next       = '0;
                    zero_op_next = 1'b0;
                    state_next   = STRIP;
                end
            end

            STRIP: begin
                // Zero operands can only be seen here on the first STRIP cycle,
                // since shifting a nonzero value right while it is even never zeroes it.
                if (x_reg == '0 || y_reg == '0) begin
                    result_next  = m_reg ? '0 : {{WIDTH{1'b0}}, x_reg | y_reg};
                    zero_op_next = 1'b1;
                    state_next   = DONE;
                end else if (!x_reg[0] && !y_reg[0]) begin
                    x_next = x_reg >> 1;
                    y_next = y_reg >> 1;
                    k_next = k_reg + KW'(1);
                end else begin
                    state_next = REDUCE;
                end
            end

            REDUCE: begin
                if (x_reg == '0) begin
                    if (m_reg) begin
                        g_next     = gcd_val;
                        q_next     = a_reg;
                        rem_next   = '0;
                        cnt_next   = KW'(WIDTH - 1);
                        state_next = DIV;
                    end else begin
                        result_next = {{WIDTH{1'b0}}, gcd_val};
                        state_next  = DONE;
                    end
                end else if (!x_reg[0]) begin
                    x_next = x_reg >> 1;
                end else if (!y_reg[0]) begin
                    y_next = y_reg >> 1;
                end else if (x_reg >= y_reg) begin
                    x_next = x_reg - y_reg;
                end else begin
                    y_next = y_reg - x_reg;
                end
            end

            DIV: begin
                // Quotient bits shift into q from the right while dividend bits leave on the left.
                if (div_shifted >= {1'b0, g_reg}) begin
                    rem_next = div_diff[WIDTH-1:0];
                    q_next   = {q_reg[WIDTH-2:0], 1'b1};
                end else begin
                    rem_next = div_shifted[WIDTH-1:0];
                    q_next   = {q_reg[WIDTH-2:0], 1'b0};
                end
                if (cnt_reg == '0) begin
                    state_next = MUL;
                end else begin
                    cnt_next = cnt_reg - KW'(1);
                end
            end

            MUL: begin
                result_next = product;
                state_next  = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign zero_op   = zero_op_reg;

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// tb_gcd_lcm_engine: directed vector table, hand-written handshake/reset sequences
// and a randomized sweep against a Euclid-based reference model.
module tb_gcd_lcm_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance signals
    logic        rst8, iv8, ir8, m8, ov8, or8, z8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] r8;

    // WIDTH=16 instance signals
    logic        rst16, iv16, ir16, m16, ov16, or16, z16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] r16;

    gcd_lcm_engine #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .reset     (rst8),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .mode      (m8),
        .a         (a8),
        .b         (b8),
        .out_valid (ov8),
        .out_ready (or8),
        .result    (r8),
        .zero_op   (z8),
        .busy      (busy8)
    );

    gcd_lcm_engine #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .reset     (rst16),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .mode      (m16),
        .a         (a16),
        .b         (b16),
        .out_valid (ov16),
        .out_ready (or16),
        .result    (r16),
        .zero_op   (z16),
        .busy      (busy16)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        mode;
        logic [15:0] res;
        logic        zop;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    function automatic logic [31:0] ref_gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [31:0] ref_lcm(input logic [31:0] a, input logic [31:0] b);
        if (a == 0 || b == 0) return 32'd0;
        return (a / ref_gcd(a, b)) * b;
    endfunction

    // One complete job on the selected instance with out_ready held high.
    // lat counts cycles from the accepting edge to out_valid.
    task automatic job(input int w, input logic [15:0] a, input logic [15:0] b, input logic m,
                       output logic [31:0] r, output logic z, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!(w == 8 ? ir8 : ir16) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) timeout_fail("in_ready_wait");
        if (w == 8) begin
            iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; m8 = m;
        end else begin
            iv16 = 1'b1; a16 = a; b16 = b; m16 = m;
        end
        @(posedge clk);
        #1;
        iv8  = 1'b0;
        iv16 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(w == 8 ? ov8 : ov16) && lat < 300);
        if (!(w == 8 ? ov8 : ov16)) timeout_fail("out_valid_wait");
        r = (w == 8) ? {16'd0, r8} : r16;
        z = (w == 8) ? z8 : z16;
        $display("txn w=%0d mode=%0d a=%0d b=%0d result=%0d zero_op=%0d latency=%0d",
                 w, m, a, b, r, z, lat);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] r;
        logic        z;
        int          lat;
        int          lat_g;
        int          lat_l;
        int          n;
        logic [15:0] ra;
        logic [15:0] rb;

        vecs[0]  = '{8'd48,  8'd18,  1'b0, 16'd6,     1'b0};
        vecs[1]  = '{8'd4,   8'd6,   1'b1, 16'd12,    1'b0};
        vecs[2]  = '{8'd255, 8'd255, 1'b1, 16'd255,   1'b0};
        vecs[3]  = '{8'd0,   8'd0,   1'b0, 16'd0,     1'b1};
        vecs[4]  = '{8'd0,   8'd9,   1'b1, 16'd0,     1'b1};
        vecs[5]  = '{8'd0,   8'd9,   1'b0, 16'd9,     1'b1};
        vecs[6]  = '{8'd12,  8'd0,   1'b0, 16'd12,    1'b1};
        vecs[7]  = '{8'd7,   8'd0,   1'b1, 16'd0,     1'b1};
        vecs[8]  = '{8'd21,  8'd14,  1'b0, 16'd7,     1'b0};
        vecs[9]  = '{8'd9,   8'd6,   1'b0, 16'd3,     1'b0};
        vecs[10] = '{8'd1,   8'd255, 1'b1, 16'd255,   1'b0};
        vecs[11] = '{8'd128, 8'd64,  1'b0, 16'd64,    1'b0};
        vecs[12] = '{8'd128, 8'd96,  1'b1, 16'd384,   1'b0};
        vecs[13] = '{8'd255, 8'd254, 1'b1, 16'd64770, 1'b0};
        vecs[14] = '{8'd17,  8'd255, 1'b0, 16'd17,    1'b0};
        vecs[15] = '{8'd1,   8'd1,   1'b0, 16'd1,     1'b0};
        vecs[16] = '{8'd200, 8'd3,   1'b0, 16'd1,     1'b0};
        vecs[17] = '{8'd240, 8'd180, 1'b1, 16'd720,   1'b0};
        vecs[18] = '{8'd250, 8'd15,  1'b1, 16'd750,   1'b0};

        rst8 = 1'b1; iv8 = 1'b0; m8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b1;
        rst16 = 1'b1; iv16 = 1'b0; m16 = 1'b0; a16 = '0; b16 = '0; or16 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", ir8, 1);
        chk("reset_out_valid", ov8, 0);
        chk("reset_busy", busy8, 0);
        chk("reset_result", r8, 0);
        chk("reset_zero_op", z8, 0);
        chk("reset16_in_ready", ir16, 1);
        chk("reset16_busy", busy16, 0);
        rst8  = 1'b0;
        rst16 = 1'b0;

        // Directed vector table on the 8-bit instance
        for (int i = 0; i < NVEC; i++) begin
            job(8, {8'd0, vecs[i].a}, {8'd0, vecs[i].b}, vecs[i].mode, r, z, lat);
            chk($sformatf("vec%0d_result", i), r, {16'd0, vecs[i].res});
            chk($sformatf("vec%0d_zero_op", i), z, vecs[i].zop);
            if (vecs[i].zop) chk($sformatf("vec%0d_zero_latency", i), lat, 2);
        end

        // Latency bound for gcd(48,18)
        job(8, 16'd48, 16'd18, 1'b0, r, z, lat);
        chk("gcd48_18_result", r, 6);
        chk("gcd48_18_latency_le26", (lat <= 26), 1);

        // LCM costs exactly WIDTH+1 extra cycles over GCD on the same operands
        job(8, 16'd4, 16'd6, 1'b0, r, z, lat_g);
        job(8, 16'd4, 16'd6, 1'b1, r, z, lat_l);
        chk("lcm4_6_result", r, 12);
        chk("lcm4_6_extra_latency", lat_l - lat_g, 9);
        job(8, 16'd255, 16'd255, 1'b0, r, z, lat_g);
        job(8, 16'd255, 16'd255, 1'b1, r, z, lat_l);
        chk("lcm255_result", r, 255);
        chk("lcm255_extra_latency", lat_l - lat_g, 9);

        // Backpressure: result holds, new input is ignored while DONE
        or8 = 1'b0;
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'd21; b8 = 8'd14; m8 = 1'b0;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ov8) timeout_fail("bp_out_valid_wait");
        iv8 = 1'b1; a8 = 8'd100; b8 = 8'd50; m8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", ov8, 1);
            chk("bp_result", r8, 7);
            chk("bp_zero_op", z8, 0);
            chk("bp_in_ready", ir8, 0);
        end
        $display("txn w=8 mode=0 a=21 b=14 result=%0d held=10", r8);
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", ov8, 0);
        chk("bp_release_in_ready", ir8, 1);
        chk("bp_release_busy", busy8, 0);

        // Reset in the middle of REDUCE discards the job
        @(negedge clk);
        iv8 = 1'b1; a8 = 8'd201; b8 = 8'd3; m8 = 1'b0;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        @(posedge clk);
        #1;
        chk("midjob_busy", busy8, 1);
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        chk("midrst_in_ready", ir8, 1);
        chk("midrst_out_valid", ov8, 0);
        chk("midrst_busy", busy8, 0);
        chk("midrst_result", r8, 0);
        $display("txn w=8 mode=0 a=201 b=3 aborted_by_reset");
        job(8, 16'd9, 16'd6, 1'b0, r, z, lat);
        chk("post_reset_gcd9_6", r, 3);

        // 16-bit instance
        job(16, 16'd65535, 16'd65534, 1'b1, r, z, lat);
        chk("w16_lcm_max", r, 32'd4294770690);
        chk("w16_lcm_max_zero_op", z, 0);
        job(16, 16'd0, 16'd65535, 1'b0, r, z, lat);
        chk("w16_gcd_zero", r, 65535);
        chk("w16_gcd_zero_op", z, 1);
        chk("w16_gcd_zero_latency", lat, 2);
        job(16, 16'd12, 16'd18, 1'b0, r, z, lat_g);
        job(16, 16'd12, 16'd18, 1'b1, r, z, lat_l);
        chk("w16_lcm12_18", r, 36);
        chk("w16_lcm_extra_latency", lat_l - lat_g, 17);

        // Randomized sweep against the reference model
        for (int md = 0; md < 2; md++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = 16'($urandom_range(0, 255));
                rb = 16'($urandom_range(0, 255));
                if (i % 61 == 0) ra = 16'd0;
                if (i % 67 == 0) rb = 16'd0;
                job(8, ra, rb, md[0], r, z, lat);
                chk("sweep8_result", r, md[0] ? ref_lcm({16'd0, ra}, {16'd0, rb})
                                              : ref_gcd({16'd0, ra}, {16'd0, rb}));
                chk("sweep8_zero_op", z, (ra == 0 || rb == 0));
            end
            for (int i = 0; i < 100; i++) begin
                ra = 16'($urandom_range(0, 65535));
                rb = 16'($urandom_range(0, 65535));
                job(16, ra, rb, md[0], r, z, lat);
                chk("sweep16_result", r, md[0] ? ref_lcm({16'd0, ra}, {16'd0, rb})
                                               : ref_gcd({16'd0, ra}, {16'd0, rb}));
                chk("sweep16_zero_op", z, (ra == 0 || rb == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
